// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the 4-bit-opcode CPU: FETCH/DECODE/EXEC/MEM/WB with req/ack memory port.
// Optional feature macro ILLEGAL_TRAP_EN: undefined opcodes trap into HALT and raise the sticky illegal flag.
module multicycle_sequencer #(
  parameter int OPW     = 4,
  parameter int ALUW    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            run,
  input  logic [OPW-1:0]  opcode,
  input  logic            alu_zero,
  input  logic            alu_neg,
  input  logic            mem_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic            mem_addr_sel,
  output logic            ir_wr,
  output logic            pc_wr,
  output logic [1:0]      pc_src,
  output logic            reg_wrt,
  output logic [1:0]      wb_sel,
  output logic [ALUW-1:0] alu_op,
  output logic [2:0]      state,
  output logic            fault,
  output logic            illegal
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd6,
    S_HALT   = 3'd7
  } state_e;

  localparam logic [OPW-1:0] OP_NOP  = OPW'(4'b0000);
  localparam logic [OPW-1:0] OP_LDX  = OPW'(4'b0001);
  localparam logic [OPW-1:0] OP_ST   = OPW'(4'b0011);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(4'b0100);
  localparam logic [OPW-1:0] OP_INC  = OPW'(4'b0101);
  localparam logic [OPW-1:0] OP_NEG  = OPW'(4'b0110);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(4'b0111);
  localparam logic [OPW-1:0] OP_J    = OPW'(4'b1000);
  localparam logic [OPW-1:0] OP_BRZ  = OPW'(4'b1001);
  localparam logic [OPW-1:0] OP_JM   = OPW'(4'b1010);
  localparam logic [OPW-1:0] OP_BRN  = OPW'(4'b1011);
  localparam logic [OPW-1:0] OP_LD   = OPW'(4'b1110);
  localparam logic [OPW-1:0] OP_SVPC = OPW'(4'b1111);

  localparam logic [ALUW-1:0] ALU_ADD  = ALUW'(4'b0000);
  localparam logic [ALUW-1:0] ALU_INC  = ALUW'(4'b0001);
  localparam logic [ALUW-1:0] ALU_NEG  = ALUW'(4'b0010);
  localparam logic [ALUW-1:0] ALU_SUB  = ALUW'(4'b0011);
  localparam logic [ALUW-1:0] ALU_PASS = ALUW'(4'b0100);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e         state_q;
  logic [OPW-1:0] op_q;
  logic           z_q, n_q;
  logic [7:0]     wait_cnt_q;
  logic           fault_q;

  logic   is_alu, is_mem, is_load, take_br, timed_out;
  state_e done_next;

  assign is_alu    = (op_q == OP_ADD) || (op_q == OP_INC) || (op_q == OP_NEG) || (op_q == OP_SUB);
  assign is_mem    = (op_q == OP_LD) || (op_q == OP_ST) || (op_q == OP_JM) || (op_q == OP_LDX);
  assign is_load   = (op_q == OP_LD) || (op_q == OP_LDX);
  assign take_br   = (op_q == OP_J) || ((op_q == OP_BRZ) && z_q) || ((op_q == OP_BRN) && n_q);
  assign timed_out = !mem_ack && (wait_cnt_q == WAIT_LAST);
  // A finished instruction parks in IDLE once run drops; it never aborts mid-flight.
  assign done_next = run ? S_FETCH : S_IDLE;

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  logic is_ill;
  assign is_ill  = (op_q == OPW'(4'b0010)) || (op_q == OPW'(4'b1100)) || (op_q == OPW'(4'b1101));
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_NOP;
      z_q        <= 1'b0;
      n_q        <= 1'b0;
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q  <= 1'b0;
`endif
    end else begin
      wait_cnt_q <= '0;
      case (state_q)
        S_IDLE: if (run) state_q <= S_FETCH;
        S_FETCH: begin
          if (mem_ack) begin
            state_q <= S_DECODE;
          end else if (timed_out) begin
            state_q <= S_FAULT;
            fault_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        S_DECODE: begin
          op_q    <= opcode;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (is_alu) begin
            z_q     <= alu_zero;
            n_q     <= alu_neg;
            state_q <= S_WB;
          end else if (is_mem) begin
            state_q <= S_MEM;
          end else if (op_q == OP_SVPC) begin
            state_q <= S_WB;
`ifdef ILLEGAL_TRAP_EN
          end else if (is_ill) begin
            state_q   <= S_HALT;
            illegal_q <= 1'b1;
`endif
          end else begin
            state_q <= done_next;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            state_q <= is_load ? S_WB : done_next;
          end else if (timed_out) begin
            state_q <= S_FAULT;
            fault_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        S_WB:    state_q <= done_next;
        S_FAULT: state_q <= S_FAULT;
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decode registered state; only the ack-qualified strobes look at mem_ack.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_wr        = 1'b0;
    pc_wr        = 1'b0;
    pc_src       = 2'b00;
    reg_wrt      = 1'b0;
    wb_sel       = 2'b00;
    alu_op       = ALU_PASS;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_wr  = 1'b1;
          pc_wr  = 1'b1;
          pc_src = 2'b01;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_ADD:                     alu_op = ALU_ADD;
          OP_INC:                     alu_op = ALU_INC;
          OP_NEG:                     alu_op = ALU_NEG;
          OP_SUB:                     alu_op = ALU_SUB;
          OP_LD, OP_ST, OP_JM, OP_LDX: alu_op = ALU_ADD;
          default:                    alu_op = ALU_PASS;
        endcase
        if (take_br) begin
          pc_wr  = 1'b1;
          pc_src = 2'b10;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (op_q == OP_ST);
        alu_op       = ALU_ADD;
        if (mem_ack && (op_q == OP_JM)) begin
          pc_wr  = 1'b1;
          pc_src = 2'b11;
        end
      end
      S_WB: begin
        reg_wrt = 1'b1;
        if (is_load)                wb_sel = 2'b01;
        else if (op_q == OP_SVPC)   wb_sel = 2'b10;
        else                        wb_sel = 2'b00;
      end
      default: ;
    endcase
  end

  assign state = state_q;
  assign fault = fault_q;

endmodule
